// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and types for the fetch queue between the PC/ROM stage and ID.
// Holds the reset, chip-enable, stall, zero-word and NOP encodings used by the pipeline.
package if_fetch_queue_pkg;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        STOP          = 1'b1;
    localparam int          INST_ADDR_BUS = 32;
    localparam int          INST_BUS      = 32;
    localparam logic [31:0] ZERO_WORD     = 32'h0;
    localparam logic [31:0] NOP_INST      = 32'h0;

    // Where the ID registers take their next value from.
    typedef enum logic [1:0] {
        ID_HOLD,
        ID_BYPASS,
        ID_DEQUEUE,
        ID_BUBBLE
    } id_src_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, inst} pairs while decode is stalled.
// The read data is the current head entry; pop advances past it.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign dout = mem[head];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch-side buffer replacing the IF/ID latch: pairs ROM data with its PC,
// queues pairs while ID stalls, and requests a PC stall before the queue overflows.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic              if_ce_i,
    input  logic [INST_W-1:0] rom_inst_i,
    input  logic [5:0]        stall,
    input  logic              flush,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_valid,
    output logic              stallreq_if
);

    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam int                ENTRY_W  = ADDR_W + INST_W;
    localparam logic [CNT_W:0]    CAPACITY = (CNT_W + 1)'(DEPTH);

    logic                inflight;
    logic [ADDR_W-1:0]   req_pc;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      occupancy;
    logic [ENTRY_W-1:0]  head_entry;
    logic                issue;
    logic                empty;
    logic                id_take;
    logic                bypass;
    logic                push;
    logic                pop;
    logic                unused_stall;
    id_src_e             id_src;

    assign issue   = (if_ce_i == CHIP_ENABLE) && (stall[0] != STOP) && !flush;
    assign empty   = (count == '0);
    assign id_take = (stall[2] != STOP);
    assign bypass  = inflight && empty && id_take;
    assign push    = inflight && !bypass && !flush;
    assign pop     = id_take && !empty && !flush;

    // The in-flight request counts against capacity so its response always has a slot.
    assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign stallreq_if = (occupancy >= CAPACITY);

    assign unused_stall = ^{stall[5:3], stall[1]};

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            inflight <= 1'b0;
            req_pc   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc <= if_pc_i;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   ({req_pc, rom_inst_i}),
        .dout  (head_entry),
        .count (count)
    );

    // Queued entries go first so that a fresh arrival never overtakes older fetches.
    always_comb begin
        id_src = ID_HOLD;
        if (id_take) begin
            if (!empty) begin
                id_src = ID_DEQUEUE;
            end else if (inflight) begin
                id_src = ID_BYPASS;
            end else begin
                id_src = ID_BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            id_pc    <= ADDR_W'(ZERO_WORD);
            id_inst  <= INST_W'(NOP_INST);
            id_valid <= 1'b0;
        end else if (flush) begin
            id_inst  <= INST_W'(NOP_INST);
            id_valid <= 1'b0;
        end else begin
            case (id_src)
                ID_DEQUEUE: begin
                    id_pc    <= head_entry[ENTRY_W-1:INST_W];
                    id_inst  <= head_entry[INST_W-1:0];
                    id_valid <= 1'b1;
                end
                ID_BYPASS: begin
                    id_pc    <= req_pc;
                    id_inst  <= rom_inst_i;
                    id_valid <= 1'b1;
                end
                ID_BUBBLE: begin
                    id_inst  <= INST_W'(NOP_INST);
                    id_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: stimulus pushes expected {pc, inst} pairs,
// a monitor pops them whenever ID loads a new valid instruction.
module tb_if_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc_i;
    logic        if_ce_i;
    logic [31:0] rom_inst_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        stallreq_if;

    logic        st2;
    logic [31:0] rom_addr_q;
    logic [63:0] exp_q [$];
    logic [63:0] exp_e;
    logic        ld;
    int          checks;
    int          errors;

    if_fetch_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .INST_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_pc_i     (if_pc_i),
        .if_ce_i     (if_ce_i),
        .rom_inst_i  (rom_inst_i),
        .stall       (stall),
        .flush       (flush),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .stallreq_if (stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl folds the fetch stall request into the PC hold bit.
    assign stall = {3'b000, st2, 1'b0, stallreq_if};

    // Synchronous ROM: data for word address n is 0xA0 + n.
    always @(posedge clk) rom_addr_q <= if_pc_i;
    assign rom_inst_i = 32'hA0 + (rom_addr_q >> 2);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic ce, input logic st2_v,
                                 input logic fl, input logic rs);
        @(negedge clk);
        if_pc_i = pc;
        if_ce_i = ce;
        st2     = st2_v;
        flush   = fl;
        rst     = rs;
        @(posedge clk);
        #2;
    endtask

    task automatic expectInst(input logic [31:0] pc, input logic [31:0] inst);
        exp_q.push_back({pc, inst});
    endtask

    // Every edge where ID was free to load and showed a valid instruction consumes one expectation.
    always @(posedge clk) begin
        ld = !rst && !flush && !stall[2];
        #1;
        if (ld && id_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_id: actual pc=%h inst=%h required no instruction", id_pc, id_inst);
            end else begin
                exp_e = exp_q.pop_front();
                checkOutput("mon_id_pc", id_pc, exp_e[63:32]);
                checkOutput("mon_id_inst", id_inst, exp_e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("count_le_depth", 32'(dut.u_fifo.count <= DEPTH), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        if_pc_i = 32'h0;
        if_ce_i = 1'b0;
        st2     = 1'b0;
        flush   = 1'b0;

        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_id_pc", id_pc, 32'h0);
        checkOutput("rst_id_inst", id_inst, 32'h0);
        checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_stallreq", 32'(stallreq_if), 32'd0);
        checkOutput("rst_count", 32'(dut.u_fifo.count), 32'd0);

        // Streaming
        expectInst(32'h0, 32'hA0);
        applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("stream_count0", 32'(dut.u_fifo.count), 32'd0);
        expectInst(32'h4, 32'hA1);
        applyStimulus(32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("stream_valid", 32'(id_valid), 32'd1);
        checkOutput("stream_count1", 32'(dut.u_fifo.count), 32'd0);
        expectInst(32'h8, 32'hA2);
        applyStimulus(32'h8, 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure: ID held for five cycles
        expectInst(32'hC, 32'hA3);
        applyStimulus(32'hC, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_count1", 32'(dut.u_fifo.count), 32'd1);
        checkOutput("bp_stallreq1", 32'(stallreq_if), 32'd1);
        applyStimulus(32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_count2", 32'(dut.u_fifo.count), 32'd2);
        checkOutput("bp_stallreq2", 32'(stallreq_if), 32'd1);
        checkOutput("bp_hold_pc", id_pc, 32'h4);
        checkOutput("bp_hold_inst", id_inst, 32'hA1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("bp_count_hold", 32'(dut.u_fifo.count), 32'd2);
        checkOutput("bp_hold_pc2", id_pc, 32'h4);
        applyStimulus(32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_drain1", 32'(dut.u_fifo.count), 32'd1);
        expectInst(32'h10, 32'hA4);
        applyStimulus(32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_drain0", 32'(dut.u_fifo.count), 32'd0);
        expectInst(32'h14, 32'hA5);
        applyStimulus(32'h14, 1'b1, 1'b0, 1'b0, 1'b0);
        expectInst(32'h18, 32'hA6);
        applyStimulus(32'h18, 1'b1, 1'b0, 1'b0, 1'b0);

        // Simultaneous arrival and dequeue with one entry queued
        expectInst(32'h1C, 32'hA7);
        applyStimulus(32'h1C, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("sim_count_pre", 32'(dut.u_fifo.count), 32'd1);
        applyStimulus(32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sim_count_same", 32'(dut.u_fifo.count), 32'd1);
        checkOutput("sim_id_pc", id_pc, 32'h18);
        expectInst(32'h20, 32'hA8);
        applyStimulus(32'h20, 1'b1, 1'b0, 1'b0, 1'b0);

        // Chip disable for three cycles
        applyStimulus(32'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ce_last_pc", id_pc, 32'h20);
        checkOutput("ce_last_valid", 32'(id_valid), 32'd1);
        applyStimulus(32'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ce_bubble_valid", 32'(id_valid), 32'd0);
        checkOutput("ce_bubble_inst", id_inst, 32'h0);
        checkOutput("ce_bubble_pc", id_pc, 32'h20);
        applyStimulus(32'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ce_bubble_valid2", 32'(id_valid), 32'd0);
        checkOutput("ce_count", 32'(dut.u_fifo.count), 32'd0);

        // Flush with a queued entry and a response in flight
        expectInst(32'h24, 32'hA9);
        applyStimulus(32'h24, 1'b1, 1'b0, 1'b0, 1'b0);
        expectInst(32'h28, 32'hAA);
        applyStimulus(32'h28, 1'b1, 1'b0, 1'b0, 1'b0);
        expectInst(32'h2C, 32'hAB);
        applyStimulus(32'h2C, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("fl_pre_count", 32'(dut.u_fifo.count), 32'd1);
        checkOutput("fl_pre_stallreq", 32'(stallreq_if), 32'd1);
        exp_q.delete();
        applyStimulus(32'h30, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("fl_valid", 32'(id_valid), 32'd0);
        checkOutput("fl_inst", id_inst, 32'h0);
        checkOutput("fl_count", 32'(dut.u_fifo.count), 32'd0);
        checkOutput("fl_stallreq", 32'(stallreq_if), 32'd0);
        expectInst(32'h100, 32'hE0);
        applyStimulus(32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fl_post_pc", id_pc, 32'h100);
        checkOutput("fl_post_inst", id_inst, 32'hE0);
        checkOutput("fl_post_valid", 32'(id_valid), 32'd1);

        // A request presented during flush must not issue
        applyStimulus(32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("fl2_valid", 32'(id_valid), 32'd0);
        applyStimulus(32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fl2_no_issue", 32'(id_valid), 32'd0);

        // Reset with a full queue
        applyStimulus(32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h304, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h308, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("mr_count_full", 32'(dut.u_fifo.count), 32'd2);
        exp_q.delete();
        applyStimulus(32'h308, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("mr_id_pc", id_pc, 32'h0);
        checkOutput("mr_id_inst", id_inst, 32'h0);
        checkOutput("mr_id_valid", 32'(id_valid), 32'd0);
        checkOutput("mr_stallreq", 32'(stallreq_if), 32'd0);
        checkOutput("mr_count", 32'(dut.u_fifo.count), 32'd0);
        expectInst(32'h0, 32'hA0);
        applyStimulus(32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mr_post_pc", id_pc, 32'h0);
        checkOutput("mr_post_inst", id_inst, 32'hA0);
        checkOutput("mr_post_valid", 32'(id_valid), 32'd1);
        applyStimulus(32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mr_bubble", 32'(id_valid), 32'd0);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
